divn_ramp_ctrl: RTL
===================

// Module: divn_ramp_ctrl
// PURPOSE
//  Sequencer that owns the PLL feedback-divider input (divn). Accepts a new target divn over a
//  valid/ready handshake, then walks divn to it in bounded steps, holding each step so the frequency
//  loops can re-settle. Afterwards it qualifies phase lock with a timeout and reports done or error.
//  Sits between the clock-management/DVFS register block and the PLL; the droop brake status feeds it.
// PARAMETERS
//  DIVW         16    width of divn / target values (unsigned)
//  DIVN_RESET   10    divn driven out of reset
//  DIVN_MIN     2     lower clamp on accepted target
//  DIVN_MAX     1023  upper clamp on accepted target
//  STEP         1     max |delta divn| per step (>=1)
//  HOLD_CYCLES  32    refclk cycles divn is held after each step (>=1)
//  LOCK_QUAL    4     consecutive locked cycles required to declare lock (>=1)
//  LOCK_TIMEOUT 4096  max refclk cycles spent in LOCK_WAIT (>=LOCK_QUAL)
// PORTS
//  refclk       in   1     reference clock; the only clock
//  reset        in   1     synchronous, active-high reset
//  req_valid    in   1     new target request
//  req_ready    out  1     request accepted at edge where req_valid & req_ready
//  req_divn     in   DIVW  requested target divn
//  locked       in   1     PLL lock state == PHASE_LOCKED (decoded at integration level)
//  brake_active in   1     droop manager state != BRAKES_OFF
//  divn         out  DIVW  divider value driven to PLL, registered
//  busy         out  1     state != IDLE
//  done         out  1     one-cycle pulse when a sequence ends (lock or timeout)
//  timeout_err  out  1     sticky: last sequence timed out; cleared on next accept
// BEHAVIOUR
//  - Reset (priority over all): state=IDLE, divn=DIVN_RESET, done=0, timeout_err=0, counters=0.
//    Reset mid-ramp aborts with no done pulse; divn returns to DIVN_RESET the next cycle.
//  - req_ready = (state==IDLE) & !reset, combinational. busy = !req_ready except during reset (busy=0).
//  - States IDLE -> STEP -> HOLD -> (STEP | LOCK_WAIT) -> IDLE.
//  - IDLE, on accept: target <= clamp(req_divn, DIVN_MIN, DIVN_MAX), timeout_err <= 0;
//    if clamped target == divn -> LOCK_WAIT (lock re-check only), else -> STEP.
//  - STEP (1 cycle): divn <= divn +/- min(STEP, |target-divn|) toward target; hold_cnt <= HOLD_CYCLES-1; -> HOLD.
//    So divn first changes at the 2nd edge after the accept edge, then every HOLD_CYCLES+1 cycles.
//  - HOLD: hold_cnt decrements; at 0: divn==target -> LOCK_WAIT (qual_cnt=0, tmo_cnt=LOCK_TIMEOUT-1), else -> STEP.
//  - LOCK_WAIT: qual_cnt counts consecutive locked=1 cycles, clears to 0 on locked=0.
//    On the edge where qual_cnt reaches LOCK_QUAL: -> IDLE, done=1 for one cycle.
//    Else if tmo_cnt==0: -> IDLE, done=1, timeout_err=1. Timeout wins if both occur on same edge? No:
//    lock qualification wins on a tie (timeout_err stays 0).
//  - divn is never outside [min(DIVN_RESET,DIVN_MIN), max(DIVN_RESET,DIVN_MAX)]; subtraction never wraps.
//  - req_valid while busy is ignored (not queued); req_divn only sampled on the accept edge.
//  - Arithmetic in DIVW+1 bits signed for delta; step clamp prevents overshoot.
// CONFIGURATION
//  DIVN_RAMP_BRAKE_PAUSE_EN defined: while brake_active=1 in STEP/HOLD/LOCK_WAIT the FSM freezes
//    (state, divn, hold_cnt, tmo_cnt held; qual_cnt cleared); it resumes the cycle after brake_active=0.
//    brake_active has no effect in IDLE.
//  Not defined: brake_active is ignored; ramp and timeout proceed through droop events.
// TESTING (defaults unless stated)
//  1 Reset -> divn=10, busy=0, req_ready=1, done=0, timeout_err=0; hold reset 3 cycles, same values.
//  2 req 13, locked=1 -> divn 11/12/13 at edges A+2, A+35, A+68; done pulse 4 cycles after LOCK_WAIT entry.
//  3 req 1 -> clamped to 2: divn steps 10..2 downward, 8 steps, done, timeout_err=0; req 5000 -> target 1023.
//  4 req 12, locked=0 -> divn reaches 12, done + timeout_err=1 after 4096 LOCK_WAIT cycles; next accept clears err.
//  5 req_valid with req 20 while busy -> ignored; reset at mid-ramp (divn=11) -> divn=10, no done pulse.
//  6 BRAKE_PAUSE_EN: brake_active=1 for 50 cycles in HOLD -> divn/counters frozen, completion delayed by exactly 50.

Source files
------------

// File: rtl/divn_ramp_ctrl.sv
// divn_ramp_ctrl: walks the PLL feedback divider to a requested target in bounded, held steps, then qualifies lock
//
// Accepts a target over req_valid/req_ready and clamps it to [DIVN_MIN, DIVN_MAX].
// It then steps divn toward the target by at most STEP per step. Each step is held for HOLD_CYCLES refclk cycles.
// After the last step it waits for LOCK_QUAL consecutive locked cycles, or gives up after LOCK_TIMEOUT cycles.
// Optional build macro: DIVN_RAMP_BRAKE_PAUSE_EN. When it is defined, brake_active freezes the sequencer outside IDLE.
// Ports:
//   refclk, reset            clock and synchronous active-high reset
//   req_valid/req_ready      target request handshake; req_divn is sampled on the accept edge
//   locked, brake_active     PLL phase-lock and droop-brake status
//   divn                     registered divider value driven to the PLL
//   busy, done, timeout_err  sequencer active, end-of-sequence pulse, sticky timeout flag
module divn_ramp_ctrl #(
    parameter int DIVW         = 16,
    parameter int DIVN_RESET   = 10,
    parameter int DIVN_MIN     = 2,
    parameter int DIVN_MAX     = 1023,
    parameter int STEP         = 1,
    parameter int HOLD_CYCLES  = 32,
    parameter int LOCK_QUAL    = 4,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic            refclk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [DIVW-1:0] req_divn,
    input  logic            locked,
    input  logic            brake_active,
    output logic [DIVW-1:0] divn,
    output logic            busy,
    output logic            done,
    output logic            timeout_err
);
    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam int QCW = $clog2(LOCK_QUAL + 1);
    localparam int TCW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [DIVW-1:0] RST_W  = DIVW'(DIVN_RESET);
    localparam logic [DIVW-1:0] MIN_W  = DIVW'(DIVN_MIN);
    localparam logic [DIVW-1:0] MAX_W  = DIVW'(DIVN_MAX);
    localparam logic [DIVW-1:0] STEP_W = DIVW'(STEP);
    typedef enum logic [1:0] {IDLE, STEP_S, HOLD, LOCK_WAIT} state_t;
    state_t state;
    // cur is the working divider value; divn is its registered copy, so each step reaches the PLL one edge later
    logic [DIVW-1:0] cur, target, tgt_c, stp, step_nxt;
    logic signed [DIVW:0] delta;
    logic [DIVW:0] mag;
    logic [HCW-1:0] hold_cnt;
    logic [QCW-1:0] qual_cnt, qual_nxt;
    logic [TCW-1:0] tmo_cnt;
    logic frz;
`ifdef DIVN_RAMP_BRAKE_PAUSE_EN
    assign frz = brake_active & (state != IDLE);
`else
    logic unused_brake;
    assign unused_brake = brake_active;
    assign frz = 1'b0;
`endif
    assign req_ready = (state == IDLE) & ~reset;
    assign busy      = (state != IDLE) & ~reset;
    always_comb begin
        tgt_c    = (req_divn < MIN_W) ? MIN_W : (req_divn > MAX_W) ? MAX_W : req_divn;
        // one extra bit keeps the signed difference from wrapping, so a step never overshoots
        delta    = $signed({1'b0, target}) - $signed({1'b0, cur});
        mag      = delta[DIVW] ? $unsigned(-delta) : $unsigned(delta);
        stp      = (mag > {1'b0, STEP_W}) ? STEP_W : mag[DIVW-1:0];
        step_nxt = delta[DIVW] ? cur - stp : cur + stp;
        qual_nxt = locked ? qual_cnt + QCW'(1) : '0;
    end
    always_ff @(posedge refclk) begin
        if (reset) begin
            state       <= IDLE;
            cur         <= RST_W;
            target      <= RST_W;
            divn        <= RST_W;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            hold_cnt    <= '0;
            qual_cnt    <= '0;
            tmo_cnt     <= '0;
        end else begin
            divn <= cur;
            done <= 1'b0;
            if (frz) begin
                qual_cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (req_valid) begin
                        target      <= tgt_c;
                        timeout_err <= 1'b0;
                        qual_cnt    <= '0;
                        tmo_cnt     <= TCW'(LOCK_TIMEOUT - 1);
                        state       <= (tgt_c == cur) ? LOCK_WAIT : STEP_S;
                    end
                    STEP_S: begin
                        cur      <= step_nxt;
                        hold_cnt <= HCW'(HOLD_CYCLES - 1);
                        state    <= HOLD;
                    end
                    HOLD: if (hold_cnt == '0) begin
                        qual_cnt <= '0;
                        tmo_cnt  <= TCW'(LOCK_TIMEOUT - 1);
                        state    <= (cur == target) ? LOCK_WAIT : STEP_S;
                    end else begin
                        hold_cnt <= hold_cnt - HCW'(1);
                    end
                    LOCK_WAIT: if (qual_nxt == QCW'(LOCK_QUAL)) begin
                        // qualification wins a tie with the timeout
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (tmo_cnt == '0) begin
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        qual_cnt <= qual_nxt;
                        tmo_cnt  <= tmo_cnt - TCW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
